pipe_scroller: RTL
==================

Name: pipe_scroller

Overview:
- Parametrised successor to the 4-deep pipe-gap shift register.
- Keeps an ordered queue of up to NUM_PIPES on-screen pipe columns. Each column has an x position, a gap height and a valid flag.
- On every frame tick it scrolls the columns left by a programmable speed, retires columns that leave the screen, and spawns new columns at a fixed spacing using the external RNG byte.
- Emits score and spawn pulses, feeds the renderer and collision logic, and is controlled by the game FSM.

Parameters:
- NUM_PIPES, 4, queue depth (max simultaneous columns), >=2.
- GAP_W, 3, gap-height field width.
- X_W, 8, x-coordinate width.
- SCREEN_X, 160, spawn x is SCREEN_X-1; must be < 2^X_W.
- SPACING, 40, pixels of scroll between spawns; must be > 2^SPEED_W-1.
- BIRD_X, 32, bird column used for scoring.
- SPEED_W, 2, speed input width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run (honoured in IDLE only).
- enable  in  1  run/hold; low pauses scrolling.
- tick  in  1  one-cycle frame strobe.
- speed  in  SPEED_W  pixels per tick.
- rand_in  in  8  RNG byte; gap = rand_in[GAP_W-1:0].
- pipe_x  out  NUM_PIPES*X_W  slot i at bits [i*X_W +: X_W]; slot 0 is oldest.
- pipe_gap  out  NUM_PIPES*GAP_W  slot i gap height.
- pipe_valid  out  NUM_PIPES  slot occupied.
- score_pulse  out  1  one cycle when a column passes BIRD_X.
- spawn_pulse  out  1  one cycle when a column is spawned.
- overflow  out  1  sticky; a spawn was dropped because the queue was full.
- state  out  2  00 IDLE, 01 RUN, 10 HOLD.

Behaviour:
- All outputs are registered. Effects of a tick sampled at edge N are visible after edge N.
- Reset (any state, mid-operation included):
  - state=IDLE; pipe_x, pipe_gap, pipe_valid, overflow all 0; both pulses 0; spawn counter 0.
- FSM:
  - IDLE -> RUN on start. The queue is cleared and the spawn counter is set to 0, so the first tick spawns.
  - RUN -> HOLD when enable=0.
  - HOLD -> RUN when enable=1.
  - start is ignored outside IDLE.
  - tick is ignored in IDLE and HOLD. Queue contents are frozen in HOLD.
- Tick in RUN, all computed from pre-tick values in one cycle:
  - Scroll: each valid slot with x >= speed gets x <= x-speed. Subtraction is done at X_W+1 bits, with no wrap.
  - Retire: a valid slot with x < speed is retired. Only slot 0 can retire, because the queue is x-ordered. On retire, slots shift down by one and the top slot is cleared.
  - Score: score_pulse=1 if any valid slot has old x >= BIRD_X and new x < BIRD_X. At most one per tick, guaranteed by the SPACING constraint.
  - Spawn decision: if counter <= speed, spawn and reload counter to SPACING; otherwise counter <= counter-speed.
  - Spawn placement: the new column is written into the first free slot after retire/shift, with x=SCREEN_X-1, gap=rand_in[GAP_W-1:0], valid=1, and spawn_pulse=1.
  - Simultaneous retire and spawn: retire/shift happens first, then the spawn fills the freed slot. A full queue therefore accepts the spawn.
  - Full queue with no retire: the spawn is dropped, the counter still reloads, overflow is set, and spawn_pulse=0.
- speed=0: nothing moves, nothing retires and the counter holds. A counter of 0 still spawns, so the first tick of a run spawns at speed 0.
- Pulses last exactly one cycle and are 0 on non-tick cycles.
- pipe_valid is always contiguous from bit 0 (thermometer form).

Test Plan:
- Reset, then start, speed=1, one tick with rand_in=8'h05 -> state=RUN; slot0 x=159, gap=5, valid=4'b0001; spawn_pulse for 1 cycle.
- 40 more ticks at speed=1 -> second spawn on tick 41, slot1 x=159, slot0 x=119; exactly 2 spawn pulses total.
- Run until slot0 x=0, then tick at speed=1 with a spawn due -> slot0 retired, queue shifted, new column in freed slot; valid stays contiguous; no overflow.
- Slot at x=32, then tick at speed=2 -> x=30 and score_pulse=1 for 1 cycle. A slot at x=33 ticked at speed=1 -> no pulse.
- SPACING=4 build, speed=3, fill to 4 valid, then spawn due with no retire -> overflow=1 (sticky), spawn_pulse=0, queue unchanged apart from scroll.
- Hold/reset: enable=0 for 10 ticks -> state=HOLD, all x frozen. Then rst mid-RUN -> all outputs 0 and state=IDLE on the next edge; ticks ignored until start.

Source files
------------

// File: rtl/pipe_scroller.sv
// pipe_scroller: ordered queue of on-screen pipe columns for the side-scroller.
// Per frame tick the columns scroll left, the oldest retires once it leaves
// the screen, and new columns spawn at a fixed scroll spacing.
module pipe_scroller #(
    parameter int unsigned NUM_PIPES = 4,
    parameter int unsigned GAP_W     = 3,
    parameter int unsigned X_W       = 8,
    parameter int unsigned SCREEN_X  = 160,
    parameter int unsigned SPACING   = 40,
    parameter int unsigned BIRD_X    = 32,
    parameter int unsigned SPEED_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       enable,
    input  logic                       tick,
    input  logic [SPEED_W-1:0]         speed,
    input  logic [7:0]                 rand_in,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x,
    output logic [NUM_PIPES*GAP_W-1:0] pipe_gap,
    output logic [NUM_PIPES-1:0]       pipe_valid,
    output logic                       score_pulse,
    output logic                       spawn_pulse,
    output logic                       overflow,
    output logic [1:0]                 state
);

    localparam int unsigned XE_W  = X_W + 1;
    localparam int unsigned CNT_W = $clog2(SPACING + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [X_W-1:0]       x_q     [NUM_PIPES];
    logic [X_W-1:0]       x_d     [NUM_PIPES];
    logic [GAP_W-1:0]     gap_q   [NUM_PIPES];
    logic [GAP_W-1:0]     gap_d   [NUM_PIPES];
    logic [NUM_PIPES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 score_q, score_d;
    logic                 spawn_q, spawn_d;
    logic                 ovf_q, ovf_d;

    logic                 clear_c;
    logic                 tick_c;
    logic [XE_W-1:0]      speed_ext_c;
    logic                 retire_c;
    logic                 score_c;
    logic                 spawn_due_c;
    logic                 placed_c;
    logic [X_W-1:0]       scr_x_c [NUM_PIPES];
    logic [X_W-1:0]       nxt_x_c [NUM_PIPES];
    logic [GAP_W-1:0]     nxt_g_c [NUM_PIPES];
    logic [NUM_PIPES-1:0] nxt_v_c;

    // Only the low GAP_W bits of the RNG byte are meaningful.
    logic rand_unused_c;
    assign rand_unused_c = ^rand_in;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start leaves IDLE, enable toggles between RUN and HOLD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)   state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_HOLD;
            ST_HOLD: if (enable)  state_d = ST_RUN;
            default:              state_d = ST_IDLE;
        endcase
    end

    // FSM controls: clear queue on run start, process ticks only while running.
    always_comb begin
        clear_c = 1'b0;
        tick_c  = 1'b0;
        case (state_q)
            ST_IDLE: clear_c = start;
            ST_RUN:  tick_c  = enable & tick;
            default: ;
        endcase
    end

    // Scroll every live column without wrapping and flag a BIRD_X crossing.
    always_comb begin
        speed_ext_c = XE_W'(speed);
        score_c     = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            scr_x_c[i] = x_q[i];
            if (valid_q[i] && ({1'b0, x_q[i]} >= speed_ext_c)) begin
                scr_x_c[i] = X_W'({1'b0, x_q[i]} - speed_ext_c);
            end
            if (valid_q[i] && (x_q[i] >= X_W'(BIRD_X)) && (scr_x_c[i] < X_W'(BIRD_X))) begin
                score_c = 1'b1;
            end
        end
        // Queue is x-ordered, so only the oldest column can fall off the left edge.
        retire_c = valid_q[0] && ({1'b0, x_q[0]} < speed_ext_c);
    end

    // Shift out a retired column, then drop a spawn into the first free slot.
    always_comb begin
        for (int i = 0; i < NUM_PIPES - 1; i++) begin
            if (retire_c) begin
                nxt_x_c[i] = scr_x_c[i+1];
                nxt_g_c[i] = gap_q[i+1];
                nxt_v_c[i] = valid_q[i+1];
            end else begin
                nxt_x_c[i] = scr_x_c[i];
                nxt_g_c[i] = gap_q[i];
                nxt_v_c[i] = valid_q[i];
            end
        end
        if (retire_c) begin
            nxt_x_c[NUM_PIPES-1] = '0;
            nxt_g_c[NUM_PIPES-1] = '0;
            nxt_v_c[NUM_PIPES-1] = 1'b0;
        end else begin
            nxt_x_c[NUM_PIPES-1] = scr_x_c[NUM_PIPES-1];
            nxt_g_c[NUM_PIPES-1] = gap_q[NUM_PIPES-1];
            nxt_v_c[NUM_PIPES-1] = valid_q[NUM_PIPES-1];
        end

        spawn_due_c = (cnt_q <= CNT_W'(speed));
        placed_c    = 1'b0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (spawn_due_c && !placed_c && !nxt_v_c[i]) begin
                nxt_x_c[i] = X_W'(SCREEN_X - 1);
                nxt_g_c[i] = rand_in[GAP_W-1:0];
                nxt_v_c[i] = 1'b1;
                placed_c   = 1'b1;
            end
        end
    end

    // Next register values: clear on run start, update on a running tick, else hold.
    always_comb begin
        x_d     = x_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        score_d = 1'b0;
        spawn_d = 1'b0;
        if (clear_c) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_d[i]   = '0;
                gap_d[i] = '0;
            end
            valid_d = '0;
            cnt_d   = '0;
        end else if (tick_c) begin
            x_d     = nxt_x_c;
            gap_d   = nxt_g_c;
            valid_d = nxt_v_c;
            cnt_d   = spawn_due_c ? CNT_W'(SPACING) : (cnt_q - CNT_W'(speed));
            score_d = score_c;
            spawn_d = placed_c;
            ovf_d   = ovf_q | (spawn_due_c & ~placed_c);
        end
    end

    // Queue, counter and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_q[i]   <= '0;
                gap_q[i] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
            score_q <= 1'b0;
            spawn_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            spawn_q <= spawn_d;
            ovf_q   <= ovf_d;
        end
    end

    // Flatten slot registers onto the renderer buses.
    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_flat
        assign pipe_x[g*X_W +: X_W]       = x_q[g];
        assign pipe_gap[g*GAP_W +: GAP_W] = gap_q[g];
    end

    assign pipe_valid  = valid_q;
    assign score_pulse = score_q;
    assign spawn_pulse = spawn_q;
    assign overflow    = ovf_q;
    assign state       = state_q;

endmodule
